fru_filter_config_loader: RTL and testbench
===========================================

# fru_filter_config_loader

Serial configuration loader that builds and commits the `BypassEn` / `RegConst` control vectors consumed by the FRU signal filter unit. Accepts a bit-serial patch frame over a valid/ready handshake and assembles it in shadow registers. Commits the frame atomically to the live outputs, so the filter never sees a partially written configuration. Sits between the patch-programming path and each filter unit instance.

## Interface
Parameters:
- `FILTER_SIZE`, 10, number of filtered signals; frame length is 2*FILTER_SIZE bits.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `cfg_valid`  input  1  a frame bit is presented on `cfg_data`.
- `cfg_data`  input  1  serial frame bit.
- `cfg_ready`  output  1  loader can accept a bit this cycle.
- `cfg_abort`  input  1  discard the partially received frame.
- `cfg_clear`  input  1  force all live `BypassEn` bits to 0 (pass-through).
- `cfg_busy`  output  1  a frame is partially received or committing.
- `cfg_done`  output  1  one-cycle pulse: a frame has just been committed.
- `BypassEn`  output  FILTER_SIZE  live select vector to the filter.
- `RegConst`  output  FILTER_SIZE  live constant vector to the filter.

## Operation
- Frame format: 2*FILTER_SIZE bits. Frame bit k, with k counted from 0 in arrival order:
  - k < FILTER_SIZE → `BypassEn[k]`.
  - else → `RegConst[k-FILTER_SIZE]`.
- Beat: a bit is accepted on an edge where `cfg_valid && cfg_ready`. The bit is written to the shadow bit selected by the bit counter, and the counter increments.
- Bit counter width: $clog2(2*FILTER_SIZE).
- States:
  - IDLE: counter = 0.
  - SHIFT: 0 < counter < 2N.
  - COMMIT: one cycle.
- Transitions:
  - IDLE→SHIFT on the first accepted beat.
  - SHIFT→COMMIT on acceptance of bit 2N-1.
  - COMMIT→IDLE unconditionally.
- COMMIT actions:
  - Shadow values are copied to `BypassEn` / `RegConst`.
  - `cfg_done` is set for the following cycle.
  - Counter and shadow registers are cleared to 0.
- `cfg_ready` = 1 in IDLE and SHIFT, 0 in COMMIT. It is decoded from registered state only and has no combinational path from inputs.
- `cfg_busy` = 1 in SHIFT and COMMIT.
- `cfg_abort` in IDLE/SHIFT:
  - Counter and shadow registers go to 0 and state goes to IDLE.
  - Live outputs are unchanged and `cfg_done` is not pulsed.
  - Abort has priority over a simultaneous accepted beat; that bit is dropped.
- `cfg_abort` in COMMIT is ignored; the commit completes.
- `cfg_clear`:
  - Sets live `BypassEn` to 0 at the next edge; `RegConst` is unchanged.
  - Does not affect the loading state.
  - If it coincides with COMMIT, clear wins for `BypassEn`. `RegConst` still takes the shadow value, and `cfg_done` still pulses.
- Reset (asynchronous, any state, including mid-frame):
  - State IDLE, counter 0, shadow registers 0.
  - `BypassEn` = 0, `RegConst` = 0.
  - `cfg_ready` = 1, `cfg_busy` = 0, `cfg_done` = 0.
  - After reset, every filter output is pass-through.

## Timing
- Throughput: one bit per cycle while `cfg_valid` is held high. A full frame takes 2N accepted beats plus one COMMIT cycle, i.e. 2N+1 cycles back to back.
- Latency: last bit accepted at edge T. COMMIT is in cycle T→T+1. Outputs change at edge T+1. `cfg_done` is high during cycle T+1→T+2.
- `cfg_ready` is low only during the COMMIT cycle. A next-frame bit offered in that cycle is not accepted and must be held by the source.
- Gaps: `cfg_valid` low in SHIFT holds the counter and shadow registers indefinitely. There is no timeout.
- Live outputs change only at a COMMIT edge, a clear edge, or on reset; they are never updated bit by bit.

## Test plan
- Reset, then N=10 with no stimulus → `BypassEn` = 0, `RegConst` = 0, `cfg_ready` = 1, `cfg_busy` = 0, `cfg_done` = 0.
- Stream 20 contiguous bits encoding `BypassEn` = 10'h2A5 and `RegConst` = 10'h0F3 (LSB first) → outputs stay 0 for 20 edges. Outputs equal 2A5/0F3 one edge after the 20th beat. `cfg_done` is high for exactly 1 cycle. `cfg_ready` is low exactly 1 cycle.
- Same frame with `cfg_valid` gaps of 3 cycles between every bit → identical final values. Commit occurs one edge after the 20th accepted beat.
- Load 10'h3FF/10'h155, then send 7 bits, then `cfg_abort` asserted together with the 8th beat → outputs stay 3FF/155 with no `cfg_done`. A subsequent full frame 001/000 commits correctly, proving the counter restarted at 0.
- `cfg_clear` asserted in the COMMIT cycle of frame 3FF/2AA → `BypassEn` = 0, `RegConst` = 2AA, `cfg_done` pulses.
- Assert `rst_n` low asynchronously (between edges) after 12 bits → outputs 0 immediately. After release, a fresh 20-bit frame commits normally.

Source files
------------

// File: rtl/fru_filter_config_loader.sv
// Bit-serial patch loader for the FRU filter BypassEn/RegConst vectors.
// Ports: clk, rst_n, cfg_valid/cfg_data/cfg_ready beat, cfg_abort, cfg_clear, cfg_busy, cfg_done, BypassEn, RegConst.
module fru_filter_config_loader #(
  parameter int FILTER_SIZE = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  input  logic                   cfg_data,
  output logic                   cfg_ready,
  input  logic                   cfg_abort,
  input  logic                   cfg_clear,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic [FILTER_SIZE-1:0] BypassEn,
  output logic [FILTER_SIZE-1:0] RegConst
);

  localparam int FL = 2 * FILTER_SIZE;
  localparam int CW = $clog2(FL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]          cnt;
  logic [FILTER_SIZE-1:0] byp_sh;
  logic [FILTER_SIZE-1:0] rc_sh;
  logic                   accept;
  logic                   last;
  logic                   drop;

  assign cfg_ready = (state != COMMIT);
  assign cfg_busy  = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign last      = (cnt == CW'(FL - 1));
  // abort only counts outside COMMIT; there it is ignored
  assign drop      = cfg_abort && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!drop && accept) begin
          state_nx = last ? COMMIT : SHIFT;
        end
      end
      SHIFT: begin
        if (drop) begin
          state_nx = IDLE;
        end else if (accept && last) begin
          state_nx = COMMIT;
        end
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      byp_sh <= '0;
      rc_sh  <= '0;
    end else if (state == COMMIT || drop) begin
      cnt    <= '0;
      byp_sh <= '0;
      rc_sh  <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < FILTER_SIZE; i++) begin
        if (cnt == CW'(i)) begin
          byp_sh[i] <= cfg_data;
        end
        if (cnt == CW'(i + FILTER_SIZE)) begin
          rc_sh[i] <= cfg_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BypassEn <= '0;
      RegConst <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= (state == COMMIT);
      if (state == COMMIT) begin
        BypassEn <= byp_sh;
        RegConst <= rc_sh;
      end
      // clear overrides a same-cycle commit for BypassEn only
      if (cfg_clear) begin
        BypassEn <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fru_filter_config_loader.sv
// Scoreboard bench for fru_filter_config_loader.
// Stimulus pushes expected commits; a monitor pops on cfg_done.
module tb_fru_filter_config_loader;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_data = 1'b0;
  logic         cfg_ready;
  logic         cfg_abort = 1'b0;
  logic         cfg_clear = 1'b0;
  logic         cfg_busy;
  logic         cfg_done;
  logic [N-1:0] BypassEn;
  logic [N-1:0] RegConst;

  int errors = 0;
  int checks = 0;
  logic [2*N-1:0] sb[$];
  logic prev_done = 1'b0;

  fru_filter_config_loader #(.FILTER_SIZE(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_abort(cfg_abort),
    .cfg_clear(cfg_clear),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .BypassEn(BypassEn),
    .RegConst(RegConst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: every cfg_done pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (rst_n && cfg_done) begin
      logic [2*N-1:0] e;
      if (prev_done) chk("done_width", 32'd2, 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("commit_byp", 32'(BypassEn), 32'(e[2*N-1:N]));
        chk("commit_rc", 32'(RegConst), 32'(e[N-1:0]));
      end
    end
    prev_done = rst_n && cfg_done;
  end

  // present one bit from a negedge; returns at the negedge after acceptance
  task automatic beat(input logic d, input logic ab);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_abort = ab;
    while (!cfg_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("ready_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic bits(input logic [N-1:0] b, input logic [N-1:0] r,
                      input int cnt, input int gap,
                      input logic [N-1:0] ob, input logic [N-1:0] orr);
    for (int k = 0; k < cnt; k++) begin
      beat(k < N ? b[k] : r[k-N], 1'b0);
      if (k < 2*N-1) begin
        chk("hold_byp", 32'(BypassEn), 32'(ob));
        chk("hold_rc", 32'(RegConst), 32'(orr));
        if (gap > 0) repeat (gap) @(negedge clk);
      end
    end
  endtask

  // full frame; we are in the COMMIT cycle when bits() returns
  task automatic frame(input logic [N-1:0] b, input logic [N-1:0] r,
                       input int gap, input logic clr,
                       input logic [N-1:0] ob, input logic [N-1:0] orr);
    sb.push_back({clr ? '0 : b, r});
    bits(b, r, 2*N, gap, ob, orr);
    chk("commit_ready_lo", 32'(cfg_ready), 32'd0);
    chk("commit_busy", 32'(cfg_busy), 32'd1);
    chk("commit_old_byp", 32'(BypassEn), 32'(ob));
    cfg_clear = clr;
    @(negedge clk);
    cfg_clear = 1'b0;
    chk("post_ready", 32'(cfg_ready), 32'd1);
    chk("post_busy", 32'(cfg_busy), 32'd0);
    chk("post_done", 32'(cfg_done), 32'd1);
    @(negedge clk);
    chk("done_cleared", 32'(cfg_done), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_byp", 32'(BypassEn), 32'd0);
    chk("rst_rc", 32'(RegConst), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);

    frame(10'h2A5, 10'h0F3, 0, 1'b0, 10'h000, 10'h000);
    frame(10'h05A, 10'h30C, 3, 1'b0, 10'h2A5, 10'h0F3);
    frame(10'h2A5, 10'h0F3, 3, 1'b0, 10'h05A, 10'h30C);

    frame(10'h3FF, 10'h155, 0, 1'b0, 10'h2A5, 10'h0F3);
    bits(10'h000, 10'h000, 7, 0, 10'h3FF, 10'h155);
    beat(1'b1, 1'b1);
    chk("abort_busy", 32'(cfg_busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_byp", 32'(BypassEn), 32'h3FF);
    chk("abort_rc", 32'(RegConst), 32'h155);
    frame(10'h001, 10'h000, 0, 1'b0, 10'h3FF, 10'h155);

    frame(10'h3FF, 10'h2AA, 0, 1'b1, 10'h001, 10'h000);
    chk("clear_byp", 32'(BypassEn), 32'h000);
    chk("clear_rc", 32'(RegConst), 32'h2AA);

    bits(10'h3C3, 10'h1E1, 12, 0, 10'h000, 10'h2AA);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_byp", 32'(BypassEn), 32'd0);
    chk("arst_rc", 32'(RegConst), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    chk("arst_busy", 32'(cfg_busy), 32'd0);
    chk("arst_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(10'h155, 10'h3AA, 1, 1'b0, 10'h000, 10'h000);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
